// File: rtl/sub_pipe_pkg.sv
// Shared helpers for the lane-split pipelined subtractor.
package sub_pipe_pkg;

  function automatic int num_lanes(input int width, input int lane_w);
    return width / lane_w;
  endfunction

endpackage

// File: rtl/sub_lane_stage.sv
// One registered LANE_W-bit lane of a + ~b + carry_in, with enable and async reset.
module sub_lane_stage #(
  parameter int LANE_W = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_en,
  input  logic [LANE_W-1:0] i_a,
  input  logic [LANE_W-1:0] i_nb,
  input  logic              i_cin,
  output logic [LANE_W-1:0] o_sum,
  output logic              o_cout
);

  logic [LANE_W:0]   w_sum;
  logic [LANE_W-1:0] r_sum;
  logic              r_borrow;

  assign w_sum = {1'b0, i_a} + {1'b0, i_nb} + {{LANE_W{1'b0}}, i_cin};

  // The carry is held inverted (as a borrow) so a cleared register reads as "no borrow".
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sum    <= '0;
      r_borrow <= 1'b0;
    end else if (i_en) begin
      r_sum    <= w_sum[LANE_W-1:0];
      r_borrow <= ~w_sum[LANE_W];
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = ~r_borrow;

endmodule

// File: rtl/sub_pipe_lanes.sv
// Fully pipelined unsigned subtractor c = a - b, one LANE_W lane per stage, valid/ready flow control.
module sub_pipe_lanes
  import sub_pipe_pkg::*;
#(
  parameter int WIDTH  = 16,
  parameter int LANE_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH:0]   c
);

  localparam int NUM_LANES = num_lanes(WIDTH, LANE_W);

  if (WIDTH % LANE_W != 0) begin : g_bad_width
    $error("sub_pipe_lanes: WIDTH must be a multiple of LANE_W");
  end

  logic                 w_en;
  logic [WIDTH-1:0]     w_nb;
  logic [NUM_LANES-1:0] r_vld;

  assign w_nb    = ~b;
  assign valid_o = r_vld[NUM_LANES-1];
  assign w_en    = ~(valid_o & ~ready_i);
  assign ready_o = w_en;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_vld <= '0;
    end else if (w_en) begin
      r_vld <= (r_vld << 1) | NUM_LANES'(valid_i);
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_stage
    // Lanes k and above of a / ~b still waiting to be resolved when they reach stage k.
    logic [WIDTH-k*LANE_W-1:0] w_src_a;
    logic [WIDTH-k*LANE_W-1:0] w_src_nb;
    logic                      w_cin;
    logic [LANE_W-1:0]         w_sum;
    logic                      w_cout;

    if (k == 0) begin : g_in
      assign w_src_a  = a;
      assign w_src_nb = w_nb;
      assign w_cin    = 1'b1;
    end else begin : g_in
      assign w_src_a  = g_stage[k-1].g_hi.r_hi_a;
      assign w_src_nb = g_stage[k-1].g_hi.r_hi_nb;
      assign w_cin    = g_stage[k-1].w_cout;
    end

    sub_lane_stage #(
      .LANE_W (LANE_W)
    ) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .i_en    (w_en),
      .i_a     (w_src_a[LANE_W-1:0]),
      .i_nb    (w_src_nb[LANE_W-1:0]),
      .i_cin   (w_cin),
      .o_sum   (w_sum),
      .o_cout  (w_cout)
    );

    if (k < NUM_LANES-1) begin : g_hi
      logic [WIDTH-(k+1)*LANE_W-1:0] r_hi_a;
      logic [WIDTH-(k+1)*LANE_W-1:0] r_hi_nb;

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_hi_a  <= '0;
          r_hi_nb <= '0;
        end else if (w_en) begin
          r_hi_a  <= w_src_a[WIDTH-k*LANE_W-1:LANE_W];
          r_hi_nb <= w_src_nb[WIDTH-k*LANE_W-1:LANE_W];
        end
      end
    end

    if (k > 0) begin : g_lo
      // Lanes below k, already resolved, travelling to the output alongside the live lane.
      logic [k*LANE_W-1:0] w_lo_src;
      logic [k*LANE_W-1:0] r_lo;

      if (k == 1) begin : g_src
        assign w_lo_src = g_stage[0].w_sum;
      end else begin : g_src
        assign w_lo_src = {g_stage[k-1].w_sum, g_stage[k-1].g_lo.r_lo};
      end

      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_lo <= '0;
        end else if (w_en) begin
          r_lo <= w_lo_src;
        end
      end
    end
  end

  if (NUM_LANES == 1) begin : g_out
    assign c = {~g_stage[0].w_cout, g_stage[0].w_sum};
  end else begin : g_out
    assign c = {~g_stage[NUM_LANES-1].w_cout, g_stage[NUM_LANES-1].w_sum,
                g_stage[NUM_LANES-1].g_lo.r_lo};
  end

endmodule

// File: tb/tb_sub_pipe_lanes.sv
// Self-checking bench for sub_pipe_lanes: directed scenarios plus randomized scoreboard runs.
module tb_sub_pipe_lanes;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        v16_i, r16_o, v16_o, rdy16_i;
  logic [15:0] a16, b16;
  logic [16:0] c16;
  logic        v24_i, r24_o, v24_o, rdy24_i;
  logic [23:0] a24, b24;
  logic [24:0] c24;

  int checks   = 0;
  int failures = 0;
  logic [16:0] q16[$];
  logic [24:0] q24[$];

  always #5 clk = ~clk;

  sub_pipe_lanes #(.WIDTH(16), .LANE_W(8)) u_dut16 (
    .clk(clk), .reset_n(reset_n), .valid_i(v16_i), .ready_o(r16_o), .a(a16), .b(b16),
    .valid_o(v16_o), .ready_i(rdy16_i), .c(c16));

  sub_pipe_lanes #(.WIDTH(24), .LANE_W(8)) u_dut24 (
    .clk(clk), .reset_n(reset_n), .valid_i(v24_i), .ready_o(r24_o), .a(a24), .b(b24),
    .valid_o(v24_o), .ready_i(rdy24_i), .c(c24));

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    v16_i = 0; rdy16_i = 1; a16 = '0; b16 = '0;
    v24_i = 0; rdy24_i = 1; a24 = '0; b24 = '0;
    repeat (3) tick();
    checks++; if (v16_o !== 1'b0) begin failures++; $display("FAIL reset_valid16: got %b expected 0", v16_o); end
    checks++; if (c16 !== 17'h0) begin failures++; $display("FAIL reset_c16: got %h expected 0", c16); end
    checks++; if (r16_o !== 1'b1) begin failures++; $display("FAIL reset_ready16: got %b expected 1", r16_o); end
    checks++; if (v24_o !== 1'b0) begin failures++; $display("FAIL reset_valid24: got %b expected 0", v24_o); end
    checks++; if (c24 !== 25'h0) begin failures++; $display("FAIL reset_c24: got %h expected 0", c24); end
    reset_n = 1'b1;
    tick();
  endtask

  task automatic test_latency;
    a16 = 16'h1234; b16 = 16'h0234; v16_i = 1; rdy16_i = 1;
    tick();
    v16_i = 0;
    checks++; if (v16_o !== 1'b0) begin failures++; $display("FAIL lat_early: valid_o got %b expected 0", v16_o); end
    tick();
    checks++; if (v16_o !== 1'b1) begin failures++; $display("FAIL lat_valid: valid_o got %b expected 1", v16_o); end
    checks++; if (c16 !== 17'h01000) begin failures++; $display("FAIL lat_value: c got %h expected 01000", c16); end
    tick();
    checks++; if (v16_o !== 1'b0) begin failures++; $display("FAIL lat_single: valid_o got %b expected 0", v16_o); end
  endtask

  task automatic test_borrow;
    a16 = 16'h0100; b16 = 16'h0001; v16_i = 1; rdy16_i = 1;
    tick();
    a16 = 16'h0000; b16 = 16'h0001;
    tick();
    v16_i = 0;
    checks++; if (v16_o !== 1'b1 || c16 !== 17'h000FF) begin failures++; $display("FAIL borrow_lane: valid %b c %h expected 1 000ff", v16_o, c16); end
    tick();
    checks++; if (v16_o !== 1'b1 || c16 !== 17'h1FFFF) begin failures++; $display("FAIL borrow_neg: valid %b c %h expected 1 1ffff", v16_o, c16); end
    tick();
  endtask

  task automatic test_stall;
    logic [15:0] sa[8];
    logic [15:0] sb[8];
    logic [16:0] e, pc;
    logic        pv, pstall;
    int sent, got;
    for (int i = 0; i < 8; i++) begin sa[i] = 16'($urandom); sb[i] = 16'($urandom); end
    sent = 0; got = 0; pstall = 0; pv = 0; pc = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      if (pstall) begin
        checks++;
        if (v16_o !== pv || c16 !== pc) begin failures++; $display("FAIL stall_hold: valid %b c %h expected %b %h", v16_o, c16, pv, pc); end
      end
      rdy16_i = !(cyc >= 4 && cyc < 7);
      v16_i = (sent < 8);
      if (sent < 8) begin a16 = sa[sent]; b16 = sb[sent]; end
      #1;
      if (cyc >= 4 && cyc < 7) begin
        checks++;
        if (r16_o !== 1'b0) begin failures++; $display("FAIL stall_ready: ready_o got %b expected 0", r16_o); end
      end
      if (v16_o && rdy16_i) begin
        checks++;
        if (q16.size() == 0) begin failures++; $display("FAIL stall_extra: unexpected c %h expected none", c16); end
        else begin
          e = q16.pop_front();
          if (c16 !== e) begin failures++; $display("FAIL stall_data: c got %h expected %h", c16, e); end
        end
        got++;
      end
      if (v16_i && r16_o) begin q16.push_back({1'b0, a16} - {1'b0, b16}); sent++; end
      pstall = v16_o && !rdy16_i; pv = v16_o; pc = c16;
      tick();
    end
    v16_i = 0; rdy16_i = 1;
    checks++;
    if (got != 8 || q16.size() != 0) begin failures++; $display("FAIL stall_count: got %0d results expected 8", got); end
  endtask

  task automatic test_alternate;
    logic        hist[32];
    logic        expv;
    logic [16:0] e;
    for (int cyc = 0; cyc < 24; cyc++) begin
      v16_i = (cyc < 20) && (cyc % 2 == 0);
      hist[cyc] = v16_i;
      a16 = 16'($urandom); b16 = 16'($urandom); rdy16_i = 1;
      #1;
      expv = (cyc >= 2) ? hist[cyc-2] : 1'b0;
      checks++;
      if (v16_o !== expv) begin failures++; $display("FAIL alt_valid: cycle %0d valid_o got %b expected %b", cyc, v16_o, expv); end
      if (v16_o) begin
        checks++;
        if (q16.size() == 0) begin failures++; $display("FAIL alt_extra: unexpected c %h expected none", c16); end
        else begin
          e = q16.pop_front();
          if (c16 !== e) begin failures++; $display("FAIL alt_data: c got %h expected %h", c16, e); end
        end
      end
      if (v16_i && r16_o) q16.push_back({1'b0, a16} - {1'b0, b16});
      tick();
    end
    v16_i = 0;
  endtask

  task automatic test_reset_flight;
    a16 = 16'h5555; b16 = 16'h1111; v16_i = 1; rdy16_i = 1;
    tick();
    a16 = 16'h7777; b16 = 16'h0101;
    tick();
    v16_i = 0;
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (v16_o !== 1'b0) begin failures++; $display("FAIL flight_valid: valid_o got %b expected 0", v16_o); end
    checks++; if (c16 !== 17'h0) begin failures++; $display("FAIL flight_c: c got %h expected 0", c16); end
    q16.delete();
    repeat (2) tick();
    reset_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (v16_o !== 1'b0) begin failures++; $display("FAIL flight_stale: valid_o got %b expected 0", v16_o); end
    end
    a16 = 16'hFFFF; b16 = 16'h0000; v16_i = 1;
    tick();
    v16_i = 0;
    checks++; if (v16_o !== 1'b0) begin failures++; $display("FAIL flight_early: valid_o got %b expected 0", v16_o); end
    tick();
    checks++; if (v16_o !== 1'b1 || c16 !== 17'h0FFFF) begin failures++; $display("FAIL flight_after: valid %b c %h expected 1 0ffff", v16_o, c16); end
    tick();
  endtask

  task automatic test_random16(input int n);
    logic [16:0] e, pc;
    logic        pv, pstall;
    int sent, got, cyc;
    sent = 0; got = 0; pstall = 0; pv = 0; pc = '0;
    for (cyc = 0; cyc < 40000 && got < n; cyc++) begin
      if (pstall) begin
        checks++;
        if (v16_o !== pv || c16 !== pc) begin failures++; $display("FAIL rnd16_hold: valid %b c %h expected %b %h", v16_o, c16, pv, pc); end
      end
      v16_i = (sent < n) && ($urandom_range(3) != 0);
      a16 = 16'($urandom); b16 = 16'($urandom);
      rdy16_i = ($urandom_range(3) != 0);
      #1;
      checks++;
      if (r16_o !== !(v16_o && !rdy16_i)) begin failures++; $display("FAIL rnd16_ready: ready_o got %b expected %b", r16_o, !(v16_o && !rdy16_i)); end
      if (v16_o && rdy16_i) begin
        checks++;
        if (q16.size() == 0) begin failures++; $display("FAIL rnd16_extra: unexpected c %h expected none", c16); end
        else begin
          e = q16.pop_front();
          if (c16 !== e) begin failures++; $display("FAIL rnd16_data: c got %h expected %h", c16, e); end
        end
        got++;
      end
      if (v16_i && r16_o) begin q16.push_back({1'b0, a16} - {1'b0, b16}); sent++; end
      pstall = v16_o && !rdy16_i; pv = v16_o; pc = c16;
      tick();
    end
    v16_i = 0; rdy16_i = 1;
    checks++;
    if (got != n || q16.size() != 0) begin failures++; $display("FAIL rnd16_count: got %0d results expected %0d", got, n); end
  endtask

  task automatic test_random24(input int n);
    logic [24:0] e, pc;
    logic        pv, pstall;
    int sent, got, cyc;
    sent = 0; got = 0; pstall = 0; pv = 0; pc = '0;
    for (cyc = 0; cyc < 30000 && got < n; cyc++) begin
      if (pstall) begin
        checks++;
        if (v24_o !== pv || c24 !== pc) begin failures++; $display("FAIL rnd24_hold: valid %b c %h expected %b %h", v24_o, c24, pv, pc); end
      end
      v24_i = (sent < n) && ($urandom_range(3) != 0);
      a24 = 24'($urandom); b24 = 24'($urandom);
      if ($urandom_range(7) == 0) a24 = '0;
      if ($urandom_range(7) == 0) b24 = '1;
      rdy24_i = ($urandom_range(3) != 0);
      #1;
      if (v24_o && rdy24_i) begin
        checks++;
        if (q24.size() == 0) begin failures++; $display("FAIL rnd24_extra: unexpected c %h expected none", c24); end
        else begin
          e = q24.pop_front();
          if (c24 !== e) begin failures++; $display("FAIL rnd24_data: c got %h expected %h", c24, e); end
        end
        got++;
      end
      if (v24_i && r24_o) begin q24.push_back({1'b0, a24} - {1'b0, b24}); sent++; end
      pstall = v24_o && !rdy24_i; pv = v24_o; pc = c24;
      tick();
    end
    v24_i = 0; rdy24_i = 1;
    checks++;
    if (got != n || q24.size() != 0) begin failures++; $display("FAIL rnd24_count: got %0d results expected %0d", got, n); end
  endtask

  task automatic test_latency24;
    a24 = 24'h000000; b24 = 24'h000001; v24_i = 1; rdy24_i = 1;
    tick();
    v24_i = 0;
    tick();
    checks++; if (v24_o !== 1'b0) begin failures++; $display("FAIL lat24_early: valid_o got %b expected 0", v24_o); end
    tick();
    checks++; if (v24_o !== 1'b1 || c24 !== 25'h1FFFFFF) begin failures++; $display("FAIL lat24_value: valid %b c %h expected 1 1ffffff", v24_o, c24); end
    tick();
  endtask

  initial begin
    test_reset();
    test_latency();
    test_borrow();
    test_stall();
    test_alternate();
    test_reset_flight();
    test_random16(10000);
    test_latency24();
    test_random24(5000);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
